// File: rtl/scr1_imem_arb_pkg.sv
// Shared types and constants for the two-requester imem arbiter.
package scr1_imem_arb_pkg;

    localparam logic [1:0] SCR1_IMEM_ARB_RESP_NOTRDY = 2'b00;
    localparam logic [1:0] SCR1_IMEM_ARB_RESP_OK     = 2'b01;
    localparam logic [1:0] SCR1_IMEM_ARB_RESP_ER     = 2'b10;

    typedef logic scr1_imem_arb_id_t;

    // One extra pointer bit distinguishes full from empty.
    function automatic int scr1_imem_arb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/scr1_imem_arb_idfifo.sv
// In-order FIFO of requester IDs for accepted, unresponded requests.
module scr1_imem_arb_idfifo
    import scr1_imem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  scr1_imem_arb_id_t i_id,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output scr1_imem_arb_id_t o_head
);

    localparam int PW = scr1_imem_arb_ptr_w(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    scr1_imem_arb_id_t r_mem [DEPTH];

    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;
    logic          w_push;
    logic          w_pop;

    assign w_widx  = r_wr[AW-1:0] & MASK;
    assign w_ridx  = r_rd[AW-1:0] & MASK;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[PW-1] != r_rd[PW-1])
                   && (w_widx == w_ridx);
    assign o_head  = r_mem[w_ridx];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset: only entries between pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_widx] <= i_id;
    end

endmodule

// File: rtl/scr1_imem_arb.sv
// Round-robin arbiter sharing one imem port between two requesters.
// Optional SCR1_IMEM_ARB_STAT_EN adds per-requester grant counters.
module scr1_imem_arb
    import scr1_imem_arb_pkg::*;
#(
    parameter int PEND_DEPTH = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_req_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_resp,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_req_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_resp,
    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    input  logic              s_req_ack,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_resp,
`ifdef SCR1_IMEM_ARB_STAT_EN
    output logic [31:0]       stat_grant0,
    output logic [31:0]       stat_grant1,
`endif
    output logic              arb_err
);

    logic              r_lock;
    scr1_imem_arb_id_t r_lock_id;
    scr1_imem_arb_id_t r_last;
    logic              r_err;

    scr1_imem_arb_id_t w_sel;
    scr1_imem_arb_id_t w_head;
    logic              w_sel_req;
    logic              w_full;
    logic              w_empty;
    logic              w_acc;
    logic              w_resp_vld;
    logic              w_pop;

    always_comb begin
        w_sel = 1'b0;
        if (r_lock)
            w_sel = r_lock_id;
        else if (m0_req && m1_req)
            w_sel = ~r_last;
        else if (m1_req)
            w_sel = 1'b1;
    end

    assign w_sel_req  = w_sel ? m1_req : m0_req;
    assign s_req      = w_sel_req & ~w_full;
    assign s_addr     = w_sel ? m1_addr : m0_addr;
    assign w_acc      = s_req & s_req_ack;
    assign m0_req_ack = w_acc & (w_sel == 1'b0);
    assign m1_req_ack = w_acc & (w_sel == 1'b1);

    assign w_resp_vld = (s_resp != SCR1_IMEM_ARB_RESP_NOTRDY);
    assign w_pop      = w_resp_vld & ~w_empty;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign m0_resp    = (w_pop && w_head == 1'b0)
                      ? s_resp : SCR1_IMEM_ARB_RESP_NOTRDY;
    assign m1_resp    = (w_pop && w_head == 1'b1)
                      ? s_resp : SCR1_IMEM_ARB_RESP_NOTRDY;
    assign arb_err    = r_err;

    scr1_imem_arb_idfifo #(
        .DEPTH (PEND_DEPTH)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc),
        .i_id    (w_sel),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // A stalled request pins the grant until the slave accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_id <= 1'b0;
            r_last    <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            if (w_acc) begin
                r_lock <= 1'b0;
                r_last <= w_sel;
            end else if (s_req) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
            if (w_resp_vld && w_empty) r_err <= 1'b1;
        end
    end

`ifdef SCR1_IMEM_ARB_STAT_EN
    logic [31:0] r_stat0;
    logic [31:0] r_stat1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (m0_req_ack && r_stat0 != '1)
                r_stat0 <= r_stat0 + 32'd1;
            if (m1_req_ack && r_stat1 != '1)
                r_stat1 <= r_stat1 + 32'd1;
        end
    end

    assign stat_grant0 = r_stat0;
    assign stat_grant1 = r_stat1;
`endif

endmodule

// File: tb/tb_scr1_imem_arb.sv
// Self-checking bench for scr1_imem_arb: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_scr1_imem_arb;
    import scr1_imem_arb_pkg::*;

    localparam logic [1:0] NR = SCR1_IMEM_ARB_RESP_NOTRDY;
    localparam logic [1:0] OK = SCR1_IMEM_ARB_RESP_OK;
    localparam logic [1:0] ER = SCR1_IMEM_ARB_RESP_ER;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_req_ack, m1_req_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_req_ack;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        arb_err;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scr1_imem_arb #(
        .PEND_DEPTH (2),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_req_ack (m0_req_ack),
        .m0_rdata   (m0_rdata),
        .m0_resp    (m0_resp),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_req_ack (m1_req_ack),
        .m1_rdata   (m1_rdata),
        .m1_resp    (m1_resp),
        .s_req      (s_req),
        .s_addr     (s_addr),
        .s_req_ack  (s_req_ack),
        .s_rdata    (s_rdata),
        .s_resp     (s_resp),
        .arb_err    (arb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0;
        s_req_ack = 0; s_resp = NR;
    endtask

    task automatic test_reset();
        idle();
        m0_addr = 0; m1_addr = 0;
        s_rdata = 32'hA5A5_0001;
        rst_n = 0;
        tick(); tick();
        #4;
        checks++; if (s_req !== 1'b0) begin errs++;
            $display("FAIL reset_sreq got=%b exp=0", s_req); end
        checks++; if ({m0_req_ack, m1_req_ack} !== 2'b00) begin errs++;
            $display("FAIL reset_ack got=%b%b exp=00",
                     m0_req_ack, m1_req_ack); end
        checks++; if ({m0_resp, m1_resp} !== 4'b0) begin errs++;
            $display("FAIL reset_resp got=%b %b exp=00 00",
                     m0_resp, m1_resp); end
        checks++; if (arb_err !== 1'b0) begin errs++;
            $display("FAIL reset_err got=%b exp=0", arb_err); end
        checks++; if (m0_rdata !== 32'hA5A5_0001) begin errs++;
            $display("FAIL reset_rdata got=%h exp=a5a50001",
                     m0_rdata); end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        m0_req = 1; m0_addr = 32'h200; s_req_ack = 1;
        #4;
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            errs++; $display("FAIL single_sreq got=%b/%h exp=1/200",
                             s_req, s_addr); end
        checks++; if ({m0_req_ack, m1_req_ack} !== 2'b10) begin
            errs++; $display("FAIL single_ack got=%b%b exp=10",
                             m0_req_ack, m1_req_ack); end
        tick();
        m0_req = 0; s_req_ack = 0;
        s_resp = OK; s_rdata = 32'h057E_4505;
        #4;
        checks++; if (m0_req_ack !== 1'b0) begin errs++;
            $display("FAIL single_ackpulse got=%b exp=0", m0_req_ack); end
        checks++; if (m0_resp !== OK || m0_rdata !== 32'h057E_4505) begin
            errs++; $display("FAIL single_resp got=%b/%h exp=01/057e4505",
                             m0_resp, m0_rdata); end
        checks++; if (m1_resp !== NR) begin errs++;
            $display("FAIL single_m1resp got=%b exp=00", m1_resp); end
        tick();
        idle();
    endtask

    // Previous grant was requester 0, so alternation starts with 1.
    task automatic test_contention();
        logic eg;
        m0_addr = 32'h1000; m1_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0);
            m0_req = 1; m1_req = 1; s_req_ack = 1;
            s_resp = (i > 0) ? OK : NR;
            s_rdata = 32'hC0DE_0000 + i;
            #4;
            checks++; if ({m1_req_ack, m0_req_ack} !== {eg, ~eg}) begin
                errs++; $display("FAIL cont_ack%0d got=%b%b exp=%b%b", i,
                                 m1_req_ack, m0_req_ack, eg, ~eg); end
            checks++; if (s_addr !== (eg ? 32'h2000 : 32'h1000)) begin
                errs++; $display("FAIL cont_addr%0d got=%h", i, s_addr); end
            if (i > 0) begin
                checks++;
                if ((eg ? {m0_resp, m1_resp} : {m1_resp, m0_resp})
                    !== {OK, NR}) begin
                    errs++; $display("FAIL cont_resp%0d got=%b %b",
                                     i, m0_resp, m1_resp); end
            end
            tick();
        end
        idle(); s_resp = OK;
        #4;
        checks++; if ({m0_resp, m1_resp} !== {OK, NR}) begin errs++;
            $display("FAIL cont_drain got=%b %b exp=01 00",
                     m0_resp, m1_resp); end
        tick();
        idle();
    endtask

    task automatic test_lock();
        m1_req = 1; m1_addr = 32'h3000; s_req_ack = 1;
        tick();
        m1_addr = 32'h3004; s_req_ack = 0; s_resp = OK;
        #4;
        checks++; if (m1_resp !== OK) begin errs++;
            $display("FAIL lock_pre_resp got=%b exp=01", m1_resp); end
        tick();
        s_resp = NR;
        m0_req = 1; m0_addr = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (s_addr !== 32'h3004 || m0_req_ack !== 1'b0
                || m1_req_ack !== 1'b0) begin
                errs++; $display("FAIL lock_hold%0d got=%h %b%b exp=3004 00",
                                 i, s_addr, m0_req_ack, m1_req_ack); end
            tick();
        end
        s_req_ack = 1;
        #4;
        checks++; if ({m0_req_ack, m1_req_ack} !== 2'b01) begin errs++;
            $display("FAIL lock_release got=%b%b exp=01",
                     m0_req_ack, m1_req_ack); end
        tick();
        m1_req = 0;
        #4;
        checks++; if (m0_req_ack !== 1'b1 || s_addr !== 32'h4000) begin
            errs++; $display("FAIL lock_next got=%b/%h exp=1/4000",
                             m0_req_ack, s_addr); end
        tick();
        idle(); s_resp = OK;
        #4;
        checks++; if ({m0_resp, m1_resp} !== {NR, OK}) begin errs++;
            $display("FAIL lock_drain1 got=%b %b exp=00 01",
                     m0_resp, m1_resp); end
        tick();
        #4;
        checks++; if ({m0_resp, m1_resp} !== {OK, NR}) begin errs++;
            $display("FAIL lock_drain0 got=%b %b exp=01 00",
                     m0_resp, m1_resp); end
        tick();
        idle();
    endtask

    task automatic test_full();
        m0_req = 1; m0_addr = 32'h5000; s_req_ack = 1;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++; if (m0_req_ack !== 1'b1) begin errs++;
                $display("FAIL full_fill%0d got=%b exp=1", i, m0_req_ack); end
            tick();
        end
        #4;
        checks++; if (s_req !== 1'b0 || m0_req_ack !== 1'b0) begin errs++;
            $display("FAIL full_block got=%b%b exp=00", s_req, m0_req_ack); end
        tick();
        s_resp = OK;
        #4;
        checks++; if (s_req !== 1'b0 || m0_resp !== OK) begin errs++;
            $display("FAIL full_nobypass got=%b/%b exp=0/01",
                     s_req, m0_resp); end
        tick();
        s_resp = NR;
        #4;
        checks++; if (s_req !== 1'b1 || m0_req_ack !== 1'b1) begin errs++;
            $display("FAIL full_reassert got=%b%b exp=11",
                     s_req, m0_req_ack); end
        tick();
        idle(); s_resp = OK;
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++; if (m0_resp !== OK) begin errs++;
                $display("FAIL full_drain%0d got=%b exp=01", i, m0_resp); end
            tick();
        end
        idle();
    endtask

    task automatic test_spurious();
        s_resp = ER;
        #4;
        checks++; if ({m0_resp, m1_resp} !== 4'b0) begin errs++;
            $display("FAIL spur_route got=%b %b exp=00 00",
                     m0_resp, m1_resp); end
        tick();
        s_resp = NR;
        #4;
        checks++; if (arb_err !== 1'b1) begin errs++;
            $display("FAIL spur_err got=%b exp=1", arb_err); end
        tick(); tick(); tick();
        checks++; if (arb_err !== 1'b1) begin errs++;
            $display("FAIL spur_sticky got=%b exp=1", arb_err); end
    endtask

    task automatic test_reset_midflight();
        m0_req = 1; m0_addr = 32'h7000; s_req_ack = 1;
        tick(); tick();
        idle();
        rst_n = 0;
        #2;
        checks++; if (arb_err !== 1'b0 || s_req !== 1'b0) begin errs++;
            $display("FAIL rstmid_clear got=%b/%b exp=0/0", arb_err, s_req); end
        tick();
        rst_n = 1;
        m1_req = 1; m1_addr = 32'h6000;
        #4;
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h6000) begin errs++;
            $display("FAIL rstmid_new got=%b/%h exp=1/6000", s_req, s_addr); end
        tick();
        m1_req = 0;
        #4;
        checks++; if (s_req !== 1'b0) begin errs++;
            $display("FAIL rstmid_drop got=%b exp=0", s_req); end
        tick();
        s_resp = OK;
        #4;
        checks++; if ({m0_resp, m1_resp} !== 4'b0) begin errs++;
            $display("FAIL rstmid_stale got=%b %b exp=00 00",
                     m0_resp, m1_resp); end
        tick();
        s_resp = NR;
        #4;
        checks++; if (arb_err !== 1'b1) begin errs++;
            $display("FAIL rstmid_err got=%b exp=1", arb_err); end
        tick();
    endtask

    // Reference: pending IDs in a queue, owner chosen from the
    // round-robin rule, a stalled request owning the port until taken.
    task automatic test_random();
        bit p0 = 0, p1 = 0, last = 1, held = 0, hid = 0, err = 0;
        bit own, oreq, esreq, acc, ea0, ea1;
        logic [1:0] er0, er1;
        bit q[$];
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1; m0_addr = $urandom; end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1; m1_addr = $urandom; end
            m0_req = p0; m1_req = p1;
            s_req_ack = $urandom_range(0, 1);
            s_rdata = $urandom;
            s_resp = NR;
            if (q.size() > 0 && $urandom_range(0, 9) < 5)
                s_resp = $urandom_range(0, 3) == 0 ? ER : OK;
            else if (q.size() == 0 && $urandom_range(0, 199) == 0)
                s_resp = OK;
            if (held) own = hid;
            else if (p0 && p1) own = ~last;
            else own = p1;
            oreq = own ? p1 : p0;
            esreq = oreq && (q.size() < 2);
            acc = esreq && s_req_ack;
            ea0 = acc && !own;
            ea1 = acc && own;
            er0 = NR; er1 = NR;
            if (s_resp != NR && q.size() > 0) begin
                if (q[0]) er1 = s_resp; else er0 = s_resp;
            end
            #4;
            checks++; if (s_req !== esreq) begin errs++;
                $display("FAIL rnd_sreq c=%0d got=%b exp=%b",
                         c, s_req, esreq); end
            if (esreq) begin
                checks++;
                if (s_addr !== (own ? m1_addr : m0_addr)) begin errs++;
                    $display("FAIL rnd_addr c=%0d got=%h", c, s_addr); end
            end
            checks++; if ({m0_req_ack, m1_req_ack} !== {ea0, ea1}) begin
                errs++; $display("FAIL rnd_ack c=%0d got=%b%b exp=%b%b", c,
                                 m0_req_ack, m1_req_ack, ea0, ea1); end
            checks++; if ({m0_resp, m1_resp} !== {er0, er1}) begin
                errs++; $display("FAIL rnd_resp c=%0d got=%b %b exp=%b %b",
                                 c, m0_resp, m1_resp, er0, er1); end
            checks++; if (m0_rdata !== s_rdata || m1_rdata !== s_rdata) begin
                errs++; $display("FAIL rnd_rdata c=%0d got=%h %h exp=%h",
                                 c, m0_rdata, m1_rdata, s_rdata); end
            checks++; if (arb_err !== err) begin errs++;
                $display("FAIL rnd_err c=%0d got=%b exp=%b",
                         c, arb_err, err); end
            tick();
            if (s_resp != NR) begin
                if (q.size() > 0) void'(q.pop_front());
                else err = 1;
            end
            if (acc) begin
                q.push_back(own);
                last = own;
                held = 0;
                if (own) p1 = 0; else p0 = 0;
            end else if (esreq) begin
                held = 1; hid = own;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/scr1_imem_arb.md
Name: scr1_imem_arb

Overview:
Two-requester arbiter sharing the single instruction-memory port (imem_* request/response protocol) between the core fetch unit (requester 0) and a secondary requester (requester 1: debug program-buffer fetch / TB loader). Sits between the core imem port and scr1_imem_ahb.
- Round-robin grant; grant held while a request is unacknowledged.
- Tracks in-flight requests in an ID FIFO and steers each in-order response back to its originator.

Parameters:
PEND_DEPTH, 2, max outstanding (accepted, unresponded) requests; power of two, >=1
ADDR_W, 32, address width
DATA_W, 32, read-data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 request
m0_addr  in  ADDR_W  requester 0 address
m0_req_ack  out  1  requester 0 request accepted
m0_rdata  out  DATA_W  requester 0 read data
m0_resp  out  2  requester 0 response (00 NOTRDY, 01 OK, 10 ERR)
m1_req, m1_addr, m1_req_ack, m1_rdata, m1_resp  same as m0_*, requester 1
s_req  out  1  request to imem slave
s_addr  out  ADDR_W  address to slave
s_req_ack  in  1  slave accepted request
s_rdata  in  DATA_W  slave read data
s_resp  in  2  slave response
arb_err  out  1  sticky: response received with no pending entry

Behaviour:
- Reset (async, rst_n=0): lock=0, last_grant=1 (requester 0 wins first tie), FIFO empty, arb_err=0. Outputs after reset: s_req=0, m*_req_ack=0, m*_resp=00, rdata pass-through of s_rdata.
- Protocol: a requester keeps req and addr stable until req_ack; a request is accepted when s_req & s_req_ack.
- Selection, unlocked: only one req -> that one; both -> the one != last_grant. Locked: keep locked selection.
- lock set when s_req=1 and s_req_ack=0; cleared on acceptance. Locked grant is never switched, even if the other requester asserts.
- s_req = selected req & !fifo_full; s_addr = selected addr (combinational). Selected req_ack = s_req_ack & s_req; unselected req_ack = 0.
- On acceptance: push selected ID into FIFO; last_grant <= selected ID.
- Response: s_resp != 00 with FIFO non-empty -> routed to head ID (resp, rdata); other requester's resp=00; pop head. Zero-cycle latency (combinational steering).
- s_resp != 00 with FIFO empty: not routed (both resp=00), arb_err <= 1 (sticky until reset).
- FIFO full: s_req forced 0 even if a pop occurs same cycle (no push/pop bypass when full). Non-full: push and pop in same cycle both apply, count unchanged.
- Pointer wrap: log2(PEND_DEPTH)+1-bit pointers; full when MSBs differ and LSBs match.
- ERR response is routed exactly as OK; arbiter does not retry.
- Reset mid-operation drops all pending IDs; responses arriving after reset set arb_err.

Optional Feature:
SCR1_IMEM_ARB_STAT_EN
- Defined: adds outputs stat_grant0, stat_grant1 (32 bit each), counting accepted requests per requester, saturating at 32'hFFFF_FFFF, cleared by reset.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- scr1_imem_arb_pkg: resp encodings (SCR1_IMEM_ARB_RESP_NOTRDY/OK/ER), requester ID type (1 bit), PEND_DEPTH pointer width function.
- Sub-module scr1_imem_arb_idfifo: ID FIFO with push/pop/full/empty/head outputs.

Test Plan:
- Single requester: m0_req=1, addr=0x200, slave acks same cycle, resp OK next cycle with rdata 0x057E4505 -> m0_req_ack pulses 1 cycle, m0_resp=01, m0_rdata=0x057E4505, m1_resp=00.
- Contention: both req every cycle, slave always acks -> grants alternate 0,1,0,1; response IDs match grant order.
- Lock: m1 granted, s_req_ack held 0 for 3 cycles while m0 asserts -> s_addr stays m1_addr, m0_req_ack=0 until m1 accepted.
- Full: PEND_DEPTH=2, two accepted, no responses -> s_req=0; one OK response -> s_req reasserts next cycle.
- Spurious: s_resp=10 with FIFO empty -> both m*_resp=00, arb_err=1 and stays 1 until rst_n low.
- Reset mid-flight: two pending, rst_n pulsed low -> FIFO empty, arb_err=0, s_req follows only new requests.
